// File: rtl/pc_sequencer.sv
// Instruction-fetch sequencer: owns the PC, runs req/ack fetches to instruction memory,
// buffers one instruction for decode and applies branch, j/jal and jr redirects.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  input  logic        redir_valid,
  input  logic [1:0]  redir_type,
  input  logic [31:0] redir_base_pc,
  input  logic [15:0] redir_imm16,
  input  logic [25:0] redir_target26,
  input  logic [31:0] redir_reg,
  input  logic        halt,
  output logic        fetch_err,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {IDLE, FETCH, KILL, HOLD, HALT} state_t;

  state_t      state, nxt_state;
  logic [31:0] pc, nxt_pc;
  logic [31:0] seq_pc, redir_target;
  logic        redir_take, redir_bad, err_next, stop, consume;

  // Redirect target decode.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    seq_pc     = redir_base_pc + 32'd4;
    redir_take = redir_valid && (redir_type != 2'b11);
    redir_bad  = redir_take && (redir_type == 2'b10) && (redir_reg[1:0] != 2'b00);
    case (redir_type)
      2'b00:   redir_target = seq_pc + {{14{redir_imm16[15]}}, redir_imm16, 2'b00};
      2'b01:   redir_target = {seq_pc[31:28], redir_target26, 2'b00};
      default: redir_target = redir_reg & ~32'h3;
    endcase
  end

  assign err_next = fetch_err | redir_bad;
  assign stop     = halt | err_next;
  assign consume  = instr_valid && id_ready;

  always_comb begin
    nxt_state = state;
    nxt_pc    = pc;
    case (state)
      IDLE:  nxt_state = redir_bad ? HALT : FETCH;
      FETCH: begin
        if (redir_take) begin
          // A redirect racing an ack throws the word away; without an ack the
          // outstanding request must still be retired through KILL.
          if (imem_ack) nxt_state = stop ? HALT : FETCH;
          else          nxt_state = KILL;
        end else if (imem_ack) begin
          nxt_state = HOLD;
          nxt_pc    = pc + 32'd4;
        end
      end
      KILL:  if (imem_ack) nxt_state = stop ? HALT : FETCH;
      HOLD: begin
        if (redir_take)    nxt_state = stop ? HALT : FETCH;
        else if (id_ready) nxt_state = halt ? HALT : FETCH;
      end
      HALT:  if (!stop) nxt_state = FETCH;
      default: nxt_state = IDLE;
    endcase
    if (redir_take) nxt_pc = redir_target;
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      fetch_err   <= 1'b0;
      instr_count <= '0;
    end else begin
      state     <= nxt_state;
      pc        <= nxt_pc;
      fetch_err <= err_next;
      imem_req  <= (nxt_state == FETCH) || (nxt_state == KILL);
      // While killing, the address of the request in flight must not move.
      if (nxt_state != KILL) imem_addr <= nxt_pc;
      if (state == FETCH && imem_ack && !redir_take) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end
      if (consume || (state == HOLD && redir_take)) instr_valid <= 1'b0;
      if (consume) instr_count <= instr_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random traffic, all scored each cycle
// against a transaction-level model of fetch addresses, buffer contents and counts.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;
  logic        id_ready;
  logic        redir_valid;
  logic [1:0]  redir_type;
  logic [31:0] redir_base_pc;
  logic [15:0] redir_imm16;
  logic [25:0] redir_target26;
  logic [31:0] redir_reg;
  logic        halt;
  logic        fetch_err;
  logic [31:0] instr_count;

  pc_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .id_ready(id_ready),
    .redir_valid(redir_valid), .redir_type(redir_type), .redir_base_pc(redir_base_pc),
    .redir_imm16(redir_imm16), .redir_target26(redir_target26), .redir_reg(redir_reg),
    .halt(halt), .fetch_err(fetch_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus controls set by the scenario tasks.
  logic        id_ready_c, halt_c, rq_valid, rand_delay;
  logic [1:0]  rq_type;
  logic [31:0] rq_base, rq_reg;
  logic [15:0] rq_imm;
  logic [25:0] rq_t26;
  int          fix_delay, cur_delay, req_age;

  // Previous-cycle snapshot and transaction model.
  logic        p_req, p_ack, p_valid, last_fresh;
  logic [31:0] p_addr;
  logic [31:0] m_pc, m_instr, m_ipc, m_count;
  logic        m_full, m_drop, m_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a3c_96e1;
  endfunction

  function automatic logic [31:0] ref_target(input logic [1:0] t, input logic [31:0] base,
                                             input logic [15:0] imm, input logic [25:0] t26,
                                             input logic [31:0] r);
    logic [31:0] nxt;
    nxt = base + 32'd4;
    case (t)
      2'b00:   return nxt + 32'(int'($signed(imm)) * 4);
      2'b01:   return (nxt & 32'hF000_0000) | (32'(t26) << 2);
      default: return r & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_instr = '0; m_ipc = '0; m_count = '0;
    m_full = 1'b0; m_drop = 1'b0; m_err = 1'b0;
    p_req = 1'b0; p_ack = 1'b0; p_valid = 1'b0; p_addr = '0; last_fresh = 1'b0;
    req_age = 0; cur_delay = 0;
  endtask

  task automatic set_redirect(input logic [1:0] t, input logic [31:0] base, input logic [15:0] imm,
                              input logic [25:0] t26, input logic [31:0] r);
    rq_valid = 1'b1; rq_type = t; rq_base = base; rq_imm = imm; rq_t26 = t26; rq_reg = r;
  endtask

  // One clock: drive inputs (memory responder included), advance, update the model, score.
  task automatic cycle();
    logic taken;
    if (imem_req && (!p_req || p_ack)) begin
      req_age   = 0;
      cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fix_delay;
    end
    p_req = imem_req; p_addr = imem_addr; p_valid = instr_valid;
    imem_ack   = imem_req && (req_age >= cur_delay);
    imem_rdata = imem_ack ? mem_word(imem_addr) : $urandom();
    if (imem_req) req_age++;
    id_ready = id_ready_c; halt = halt_c;
    redir_valid = rq_valid; redir_type = rq_type; redir_base_pc = rq_base;
    redir_imm16 = rq_imm; redir_target26 = rq_t26; redir_reg = rq_reg;
    @(posedge clk); #1;
    p_ack = imem_ack;
    taken = redir_valid && (redir_type != 2'b11);
    if (p_valid && id_ready) begin m_count = m_count + 32'd1; m_full = 1'b0; end
    if (imem_ack) begin
      if (!m_drop && !taken) begin
        m_full = 1'b1; m_instr = mem_word(p_addr); m_ipc = p_addr; m_pc = p_addr + 32'd4;
      end
      m_drop = 1'b0;
    end
    if (taken) begin
      m_full = 1'b0;
      m_pc   = ref_target(redir_type, redir_base_pc, redir_imm16, redir_target26, redir_reg);
      if (redir_type == 2'b10 && redir_reg[1:0] != 2'b00) m_err = 1'b1;
      if (p_req && !imem_ack) m_drop = 1'b1;
    end
    last_fresh = imem_req && (!p_req || p_ack);

    n_checks++;
    if (instr_valid !== m_full) begin
      n_fail++; $display("FAIL instr_valid @%0t: got %b expected %b", $time, instr_valid, m_full);
    end
    if (m_full) begin
      n_checks++;
      if (instr !== m_instr || instr_pc !== m_ipc) begin
        n_fail++; $display("FAIL buffer @%0t: got %h/%h expected %h/%h", $time, instr, instr_pc, m_instr, m_ipc);
      end
    end
    n_checks++;
    if (instr_count !== m_count) begin
      n_fail++; $display("FAIL instr_count @%0t: got %0d expected %0d", $time, instr_count, m_count);
    end
    n_checks++;
    if (fetch_err !== m_err) begin
      n_fail++; $display("FAIL fetch_err @%0t: got %b expected %b", $time, fetch_err, m_err);
    end
    if (last_fresh) begin
      n_checks++;
      if (imem_addr !== m_pc || halt || m_err) begin
        n_fail++; $display("FAIL new_req @%0t: addr %h expected %h (halt %b err %b)", $time, imem_addr, m_pc, halt, m_err);
      end
    end else if (imem_req) begin
      n_checks++;
      if (imem_addr !== p_addr) begin
        n_fail++; $display("FAIL addr_hold @%0t: got %h expected %h", $time, imem_addr, p_addr);
      end
    end
    n_checks++;
    if ((imem_req && instr_valid) || (!imem_req && !instr_valid && !halt && !m_err)) begin
      n_fail++; $display("FAIL progress @%0t: req %b valid %b", $time, imem_req, instr_valid);
    end
    rq_valid = 1'b0; redir_valid = 1'b0;
  endtask

  task automatic assert_reset();
    rst_n = 1'b0; id_ready_c = 1'b0; halt_c = 1'b0; rq_valid = 1'b0;
    imem_ack = 1'b0; redir_valid = 1'b0; id_ready = 1'b0; halt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20 && !instr_valid; i++) cycle();
    n_checks++;
    if (!instr_valid) begin n_fail++; $display("FAIL wait_valid: got 0 expected 1 within 20 cycles"); end
  endtask

  task automatic test_reset();
    assert_reset();
    n_checks++;
    if ({imem_req, instr_valid, fetch_err} !== 3'b000 || instr !== 32'h0 || instr_pc !== 32'h0 ||
        instr_count !== 32'h0 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL reset_state: req %b valid %b err %b instr %h pc %h cnt %0d addr %h",
                         imem_req, instr_valid, fetch_err, instr, instr_pc, instr_count, imem_addr);
    end
    release_reset();
  endtask

  task automatic test_sequential();
    int k = 0, last = 0;
    fix_delay = 0; id_ready_c = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (last_fresh) begin
        n_checks++;
        if (imem_addr !== RESET_PC + 32'(4 * k) || (k > 0 && i - last != 2)) begin
          n_fail++; $display("FAIL seq_fetch %0d: addr %h gap %0d expected %h gap 2", k, imem_addr, i - last, RESET_PC + 32'(4 * k));
        end
        k++; last = i;
      end
    end
    n_checks++;
    if (k != 8 || instr_count !== 32'd7) begin
      n_fail++; $display("FAIL seq_count: fetches %0d count %0d expected 8 and 7", k, instr_count);
    end
  endtask

  task automatic test_redirects();
    logic [1:0]  t   [4] = '{2'b00, 2'b00, 2'b01, 2'b10};
    logic [31:0] b   [4] = '{32'h0040_0010, 32'h0040_0010, 32'hF000_0000, 32'h0040_0000};
    logic [15:0] im  [4] = '{16'hFFFF, 16'h7FFF, 16'h0000, 16'h0000};
    logic [25:0] t26 [4] = '{26'h0, 26'h0, 26'h000_0100, 26'h0};
    logic [31:0] r   [4] = '{32'h0, 32'h0, 32'h0, 32'h0040_0100};
    logic [31:0] exp [4] = '{32'h0040_0010, 32'h0042_0010, 32'hF000_0400, 32'h0040_0100};
    id_ready_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_valid();
      set_redirect(t[i], b[i], im[i], t26[i], r[i]);
      cycle();
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp[i] || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL redirect %0d: req %b addr %h expected req 1 addr %h", i, imem_req, imem_addr, exp[i]);
      end
    end
  endtask

  task automatic test_kill();
    logic done = 1'b0;
    fix_delay = 3; id_ready_c = 1'b0;
    set_redirect(2'b00, 32'h0040_0100, 16'h0010, 26'h0, 32'h0);
    cycle();
    for (int i = 0; i < 10 && !done; i++) begin
      n_checks++;
      if (imem_ack) begin
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0144 || instr_valid !== 1'b0) begin
          n_fail++; $display("FAIL kill_refetch: req %b addr %h expected 1 00400144", imem_req, imem_addr);
        end
        done = 1'b1;
      end else begin
        if (imem_req !== 1'b1 || imem_addr !== 32'h0040_0100 || instr_valid !== 1'b0) begin
          n_fail++; $display("FAIL kill_hold: req %b addr %h valid %b expected 1 00400100 0", imem_req, imem_addr, instr_valid);
        end
        cycle();
      end
    end
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL kill_timeout: got no ack expected one within 10 cycles"); end
    fix_delay = 0;
    wait_valid();
    n_checks++;
    if (instr_pc !== 32'h0040_0144 || instr !== mem_word(32'h0040_0144)) begin
      n_fail++; $display("FAIL kill_deliver: pc %h instr %h expected 00400144 %h", instr_pc, instr, mem_word(32'h0040_0144));
    end
  endtask

  task automatic test_stall();
    logic [31:0] s_instr = m_instr, s_pc = m_ipc, s_cnt = m_count;
    id_ready_c = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_checks++;
      if (instr !== s_instr || instr_pc !== s_pc || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall %0d: instr %h pc %h req %b expected %h %h 0", i, instr, instr_pc, imem_req, s_instr, s_pc);
      end
    end
    id_ready_c = 1'b1;
    cycle();
    n_checks++;
    if (instr_valid !== 1'b0 || instr_count !== s_cnt + 32'd1) begin
      n_fail++; $display("FAIL stall_release: valid %b count %0d expected 0 %0d", instr_valid, instr_count, s_cnt + 32'd1);
    end
  endtask

  task automatic test_halt();
    logic [31:0] s_pc;
    id_ready_c = 1'b0;
    wait_valid();
    s_pc = m_ipc;
    halt_c = 1'b1; id_ready_c = 1'b1;
    cycle();
    id_ready_c = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL halt_hold %0d: req %b valid %b expected 0 0", i, imem_req, instr_valid);
      end
      cycle();
    end
    halt_c = 1'b0;
    cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== s_pc + 32'd4) begin
      n_fail++; $display("FAIL halt_resume: req %b addr %h expected 1 %h", imem_req, imem_addr, s_pc + 32'd4);
    end
  endtask

  task automatic test_random();
    rand_delay = 1'b1;
    for (int i = 0; i < 400; i++) begin
      id_ready_c = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 12)
        set_redirect(2'($urandom_range(0, 3)), $urandom() & 32'hFFFF_FFFC, 16'($urandom()),
                     26'($urandom()), $urandom() & 32'hFFFF_FFFC);
      cycle();
    end
    rand_delay = 1'b0;
  endtask

  task automatic test_reset_mid_kill();
    fix_delay = 4; id_ready_c = 1'b1;
    for (int i = 0; i < 20 && !last_fresh; i++) cycle();
    set_redirect(2'b00, 32'h0000_1000, 16'h0000, 26'h0, 32'h0);
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({imem_req, instr_valid, fetch_err} !== 3'b000 || instr !== 32'h0 || instr_pc !== 32'h0 ||
        instr_count !== 32'h0 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL mid_kill_reset: req %b valid %b err %b instr %h pc %h cnt %0d addr %h",
                         imem_req, instr_valid, fetch_err, instr, instr_pc, instr_count, imem_addr);
    end
    assert_reset();
    release_reset();
    fix_delay = 0;
    cycle();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL restart: req %b addr %h expected 1 %h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_misaligned_jr();
    id_ready_c = 1'b0;
    wait_valid();
    set_redirect(2'b10, 32'h0040_0000, 16'h0, 26'h0, 32'h0040_0102);
    cycle();
    id_ready_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        n_fail++; $display("FAIL jr_misaligned %0d: err %b req %b valid %b expected 1 0 0", i, fetch_err, imem_req, instr_valid);
      end
      cycle();
    end
    assert_reset();
    release_reset();
    fix_delay = 3;
    cycle();
    set_redirect(2'b10, 32'h0040_0000, 16'h0, 26'h0, 32'h0040_0106);
    cycle();
    n_checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL jr_kill: err %b req %b addr %h expected 1 1 %h", fetch_err, imem_req, imem_addr, RESET_PC);
    end
    repeat (6) cycle();
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b1) begin
      n_fail++; $display("FAIL jr_kill_halt: req %b valid %b err %b expected 0 0 1", imem_req, instr_valid, fetch_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0; halt = 1'b0;
    redir_valid = 1'b0; redir_type = '0; redir_base_pc = '0; redir_imm16 = '0;
    redir_target26 = '0; redir_reg = '0;
    rq_type = '0; rq_base = '0; rq_imm = '0; rq_t26 = '0; rq_reg = '0;
    rand_delay = 1'b0; fix_delay = 0;
    test_reset();
    test_sequential();
    test_redirects();
    test_kill();
    test_stall();
    test_halt();
    test_random();
    test_reset_mid_kill();
    test_misaligned_jr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
